axi4_lite_master_write_engine: RTL
==================================

Name: axi4_lite_master_write_engine

Overview:
Initiator-side AXI4-Lite write engine. It pairs with the slave write interface: it drives the AW and W channels and consumes the B channel. A local command port (valid/ready) supplies one write (address, data, strobe, prot). The engine issues the write on AXI, waits for the response, and returns it on a local response port. Only one write is outstanding at a time, and a B-channel timeout guards against a hung slave.

Parameters:
ADDRESS_WIDTH, 32, AW address width (default from Axi4LiteGlobalsPkg)
DATA_WIDTH, 32, W data width; strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 256, cycles to wait for bvalid after AW and W both complete; 0 disables the timeout

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_addr  in  ADDRESS_WIDTH  write address
cmd_data  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  byte strobes
cmd_prot  in  3  protection bits
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_resp  out  2  BRESP value, or 2'b10 on timeout
rsp_timeout  out  1  response was generated by a timeout
awaddr  out  ADDRESS_WIDTH  AW address
awprot  out  3  AW prot
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  DATA_WIDTH  W data
wstrb  out  DATA_WIDTH/8  W strobes
wvalid  out  1  W valid
wready  in  1  W ready
bresp  in  2  B response
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs are 0, the FSM goes to IDLE, and the timer is 0.
  - Reset mid-transaction abandons the transaction with no response.
- States: IDLE, ADDR_DATA, WAIT_RESP, RSP_OUT, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture addr/data/strb/prot into registers and go to ADDR_DATA.
  - awvalid and wvalid rise on the next cycle (1-cycle issue latency).
- ADDR_DATA:
  - AW and W are independent. Track them with flags aw_done and w_done.
  - awvalid stays high until awvalid&awready, then drops next cycle. Same rule for wvalid with wready.
  - Completion order between AW and W is free, including the same cycle.
  - awaddr/awprot/wdata/wstrb are stable while the matching valid is high.
  - Neither valid drops before its handshake (AXI rule).
  - When both handshakes have occurred, go to WAIT_RESP; the timer clears.
- WAIT_RESP:
  - bready=1.
  - On bvalid, latch bresp into rsp_resp, set rsp_timeout=0, go to RSP_OUT.
  - Otherwise the timer increments. When it reaches TIMEOUT_CYCLES-1 without bvalid, set rsp_resp=2'b10 and rsp_timeout=1, go to RSP_OUT, and set a stale_b flag.
  - If bvalid arrives on the same cycle as the timeout, it takes priority: a normal response, no stale_b.
- RSP_OUT:
  - rsp_valid=1 and bready=0; rsp fields are stable until rsp_ready.
  - On rsp_ready, go to DRAIN if stale_b is set, else to IDLE.
- DRAIN:
  - bready=1 and cmd_ready=0.
  - The first bvalid is discarded, stale_b clears, go to IDLE.
  - DRAIN has no timeout (protocol-correct; no new AW is issued while a B is owed).
- Throughput: at best 1 write per 4 cycles (IDLE, ADDR_DATA, WAIT_RESP, RSP_OUT).
- bready is never asserted outside WAIT_RESP/DRAIN. A bvalid seen in other states is a slave protocol error; it is ignored and causes no state change.
- Timer width is $clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.

Decomposition:
- Axi4LiteGlobalsPkg holds:
  - ADDRESS_WIDTH and DATA_WIDTH
  - resp typedef enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3
  - state typedef for this FSM
- One sub-module, axi4_lite_resp_timer: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES.

Test Plan:
1. Single write, addr=0x1000, data=0xDEADBEEF, strb=0xF: slave asserts awready/wready the cycle after valid and bvalid 2 cycles later with OKAY -> awvalid and wvalid each high exactly 2 cycles, rsp_valid with rsp_resp=0, rsp_timeout=0.
2. W before AW: wready held high, awready delayed 5 cycles -> wvalid drops after 1 handshake, awvalid held 6 cycles with awaddr stable, exactly one B accepted.
3. Slave returns SLVERR on a write to 0x2004 -> rsp_resp=2'b10, rsp_timeout=0. rsp_ready held low 4 cycles -> rsp fields stable, cmd_ready=0 throughout.
4. TIMEOUT_CYCLES=16, bvalid withheld -> rsp_valid with rsp_timeout=1, rsp_resp=2'b10, 16 cycles after the last AW/W handshake. A late bvalid at cycle 30 is absorbed in DRAIN, then cmd_ready returns to 1.
5. aresetn pulsed low while awvalid=1 and wvalid=0 -> awvalid, wvalid, bready, rsp_valid and cmd_ready are 0 immediately, without waiting for an aclk edge. After release the FSM is in IDLE and the next command runs normally.
6. Back-to-back: 8 commands with cmd_valid held high and a zero-wait slave -> 8 responses in order, each OKAY, no overlapping AW transactions.

Source files
------------

// File: rtl/axi4_lite_master_write_engine_pkg.sv
// Shared AXI4-Lite widths, response codes and write-engine FSM states.
// Also provides the timer width helper used by the response timer.
package Axi4LiteGlobalsPkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR_DATA = 3'd1,
        WAIT_RESP = 3'd2,
        RSP_OUT   = 3'd3,
        DRAIN     = 3'd4
    } wr_state_t;

    // A disabled timer (0 cycles) still needs a 1-bit counter.
    function automatic int timer_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_master_write_engine_resp_timer.sv
// Saturating B-channel wait timer for the write engine.
// expired flags the last permitted wait cycle; 0 cycles disables it.
module axi4_lite_resp_timer
    import Axi4LiteGlobalsPkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = timer_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/axi4_lite_master_write_engine.sv
// AXI4-Lite single-outstanding write initiator with B-channel timeout.
// Local command in, AW/W out, B in, local response out.
module axi4_lite_master_write_engine #(
    parameter int ADDRESS_WIDTH  = Axi4LiteGlobalsPkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = Axi4LiteGlobalsPkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDRESS_WIDTH-1:0]  awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    import Axi4LiteGlobalsPkg::*;

    localparam int SW = DATA_WIDTH / 8;

    wr_state_t state;
    wr_state_t state_d;

    logic                     live;
    logic                     aw_done;
    logic                     w_done;
    logic                     stale_b;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [SW-1:0]            strb_q;
    logic [2:0]               prot_q;
    logic [1:0]               resp_q;
    logic                     timeout_q;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic both_done;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    assign accept    = cmd_valid & cmd_ready;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign both_done = (aw_done | aw_hs) & (w_done | w_hs);

    assign tmr_clear  = (state != WAIT_RESP);
    assign tmr_enable = (state == WAIT_RESP) & ~bvalid;

    axi4_lite_resp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept) state_d = ADDR_DATA;
            end
            ADDR_DATA: begin
                if (both_done) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (bvalid || tmr_expired) state_d = RSP_OUT;
            end
            RSP_OUT: begin
                if (rsp_ready) state_d = stale_b ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (bvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // cmd_ready is held low until the first edge after reset release.
    always_comb begin
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE:      cmd_ready = live;
            ADDR_DATA: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
            end
            WAIT_RESP: bready    = 1'b1;
            RSP_OUT:   rsp_valid = 1'b1;
            DRAIN:     bready    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live      <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            stale_b   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                strb_q <= cmd_strb;
                prot_q <= cmd_prot;
            end
            if (state == ADDR_DATA) begin
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | w_hs;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            // A B beat on the expiry cycle wins over the timeout.
            if (state == WAIT_RESP) begin
                if (bvalid) begin
                    resp_q    <= bresp;
                    timeout_q <= 1'b0;
                end else if (tmr_expired) begin
                    resp_q    <= SLVERR;
                    timeout_q <= 1'b1;
                    stale_b   <= 1'b1;
                end
            end
            if ((state == DRAIN) && bvalid) begin
                stale_b <= 1'b0;
            end
        end
    end

    assign awaddr      = addr_q;
    assign awprot      = prot_q;
    assign wdata       = data_q;
    assign wstrb       = strb_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;

endmodule
